// File: rtl/ps2_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scan_ctrl_pkg
// Shared constants for the PS/2 scan-code controller: set-2 prefix bytes,
// parser state encodings and the event record handed to the consumer.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_scan_ctrl_pkg;

  // set-2 prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // parser states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXT    = 3'd1;
  localparam logic [2:0] ST_BRK    = 3'd2;
  localparam logic [2:0] ST_EXTBRK = 3'd3;
  localparam logic [2:0] ST_PAUSE  = 3'd4;

  // bytes that follow E1 in the pause sequence before the event is emitted
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

endpackage

// File: rtl/ps2_tmo_cnt.sv
// ---------------------------------------------------------------------------
// ps2_tmo_cnt
// Inter-byte timeout counter. Counts while run=1 and produces a one-cycle
// expire tick when TMO_CYC-1 is reached. clr restarts the count and also
// suppresses the tick, so a byte landing on the terminal cycle wins.
//
// Ports
//   clk     in   system clock
//   reset   in   asynchronous active-high reset
//   clr     in   restart the count (a byte was received)
//   run     in   count enable (parser is inside a sequence)
//   expire  out  one-cycle timeout tick
// ---------------------------------------------------------------------------
module ps2_tmo_cnt #(
  parameter int TMO_CYC = 100000,
  parameter int TMO_W   = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [TMO_W-1:0] TC  = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || !run) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  assign expire = run && !clr && (cnt == TC);

endmodule

// File: rtl/ps2_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_scan_ctrl
// Turns the raw byte stream from ps2_rx into complete set-2 key events
// (make/break, extended, pause) and presents them one at a time through a
// valid/ack handshake. Truncated prefixes are abandoned after TMO_CYC idle
// cycles. Events completing while one is still pending are dropped and
// flagged on the sticky overflow output.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   enable     in   consumer permits reception
//   rx_done    in   one-cycle byte tick from ps2_rx
//   rx_data    in   received byte, valid with rx_done
//   rx_en      out  registered receiver enable (enable delayed one cycle)
//   key_valid  out  event pending
//   key_code   out  final scan code
//   key_ext    out  event carried E0
//   key_break  out  event is a release
//   key_ack    in   consumer takes the event
//   overflow   out  sticky: a completed event was dropped
//   clr_ovf    in   clear overflow
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for first byte of a sequence
// ST_EXT    | E0 seen, waiting for F0 or the code
// ST_BRK    | F0 seen, next byte is the released code
// ST_EXTBRK | E0 F0 seen, next byte is the released code
// ST_PAUSE  | E1 seen, swallowing the rest of the pause sequence
// ---------------------------------------------------------------------------
module ps2_scan_ctrl
  import ps2_scan_ctrl_pkg::*;
#(
  parameter int TMO_CYC = 100000,
  parameter int TMO_W   = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  input  logic       key_ack,
  output logic       overflow,
  input  logic       clr_ovf
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] skip_cnt;
  logic [2:0] skip_nxt;
  logic       byte_vld;
  logic       emit;
  key_evt_t   emit_evt;
  logic       tmo_expire;
  logic       evt_load;
  logic       evt_drop;

  assign byte_vld = rx_done && rx_en;

  ps2_tmo_cnt #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (byte_vld),
    .run    (state != ST_IDLE),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    emit      = 1'b0;
    emit_evt  = '{code: rx_data, ext: 1'b0, brk: 1'b0};

    if (byte_vld) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == PS2_EXT) begin
            state_nxt = ST_EXT;
          end else if (rx_data == PS2_BRK) begin
            state_nxt = ST_BRK;
          end else if (rx_data == PS2_PAUSE) begin
            state_nxt = ST_PAUSE;
            skip_nxt  = PAUSE_SKIP;
          end else begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_nxt = ST_EXTBRK;
          end else if (rx_data != PS2_EXT) begin
            // repeated E0 keeps waiting; anything else completes the key
            emit         = 1'b1;
            emit_evt.ext = 1'b1;
            state_nxt    = ST_IDLE;
          end
        end
        ST_BRK: begin
          // E0/F0 are ordinary data once a break prefix is open
          emit         = 1'b1;
          emit_evt.brk = 1'b1;
          state_nxt    = ST_IDLE;
        end
        ST_EXTBRK: begin
          emit         = 1'b1;
          emit_evt.ext = 1'b1;
          emit_evt.brk = 1'b1;
          state_nxt    = ST_IDLE;
        end
        ST_PAUSE: begin
          if (skip_cnt == 3'd1) begin
            emit          = 1'b1;
            emit_evt.code = PS2_PAUSE;
            skip_nxt      = 3'd0;
            state_nxt     = ST_IDLE;
          end else begin
            skip_nxt = skip_cnt - 3'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          skip_nxt  = 3'd0;
        end
      endcase
    end else if (tmo_expire) begin
      // partial sequence abandoned silently
      state_nxt = ST_IDLE;
      skip_nxt  = 3'd0;
    end

    // losing the receive permission ends any sequence in flight
    if (!enable) begin
      state_nxt = ST_IDLE;
      skip_nxt  = 3'd0;
    end
  end

  // a pending event can be replaced only in the cycle it is being acked
  assign evt_load = emit && (!key_valid || key_ack);
  assign evt_drop = emit && key_valid && !key_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
      rx_en    <= 1'b0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      rx_en    <= enable;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
    end else if (evt_load) begin
      key_valid <= 1'b1;
      key_code  <= emit_evt.code;
      key_ext   <= emit_evt.ext;
      key_break <= emit_evt.brk;
    end else if (key_ack) begin
      key_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (evt_drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
